// File: rtl/jtframe_nvram_upload_if.sv
// Purpose: hps_io upload channel plus game NVRAM read port, grouped for the NVRAM upload responder.
// Latency: none, wiring only.
// Backpressure: hps_wait stalls hps_io; ram_cs is held until ram_ok or timeout.
interface jtframe_nvram_upload_if #(
    parameter int AW = 13
);
    // hps_io side
    logic          hps_upload;
    logic [7:0]    hps_index;
    logic          hps_rd;
    logic [26:0]   hps_addr;
    logic [7:0]    hps_din;
    logic          hps_wait;
    // game NVRAM side
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_ok;
    logic [7:0]    ram_dout;
    // status towards the game
    logic          uploading;
    logic          upload_end;
    logic          tout_err;

    // The responder block
    modport slave (
        input  hps_upload, hps_index, hps_rd, hps_addr, ram_ok, ram_dout,
        output hps_din, hps_wait, ram_addr, ram_cs, uploading, upload_end, tout_err
    );

    // hps_io and NVRAM together, as seen from outside the responder
    modport master (
        output hps_upload, hps_index, hps_rd, hps_addr, ram_ok, ram_dout,
        input  hps_din, hps_wait, ram_addr, ram_cs, uploading, upload_end, tout_err
    );
endinterface

// File: rtl/jtframe_nvram_upload.sv
// Purpose: serves hps_io upload byte reads (NVRAM save) by fetching each byte from game NVRAM.
// Latency: 3+ cycles per in-range byte (request, arm, wait for ram_ok); 1 cycle for out-of-range bytes.
// Backpressure: hps_wait stalls hps_io from the request cycle until the byte sits in hps_din.
module jtframe_nvram_upload #(
    parameter int         AW          = 13,
    parameter logic [7:0] NVRAM_INDEX = 8'd2,
    parameter int         TOUT        = 255
)(
    input  logic                  clk,
    input  logic                  rst_n,
    jtframe_nvram_upload_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TOUT_C = 8'(TOUT);

    state_t        state_q;
    logic [7:0]    timer_q;
    logic [7:0]    timer_d;
    logic [7:0]    hps_din_q;
    logic [AW-1:0] ram_addr_q;
    logic          tout_err_q;
    logic          uploading_q;
    logic          uploading_d;
    logic          upload_end_q;

    logic          sess;
    logic          sess_rise;
    logic          in_range;
    logic          req;
    logic          timeout;

    // A session is only ours when hps_io is uploading the NVRAM file index.
    assign sess        = bus.hps_upload && (bus.hps_index == NVRAM_INDEX);
    assign uploading_d = sess;
    assign sess_rise   = sess && !uploading_q;

    // Any address bit above the NVRAM window makes the request out of range.
    assign in_range = (bus.hps_addr >> AW) == 27'd0;
    assign req      = bus.hps_rd && sess;

    assign timer_d  = timer_q + 8'd1;
    assign timeout  = (timer_q == TOUT_C);

    // Fetch FSM: latch the address, skip one cycle so a stale ram_ok from the
    // previous access cannot be mistaken for ours, then wait for data or give up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= 8'd0;
            hps_din_q  <= 8'd0;
            ram_addr_q <= '0;
            tout_err_q <= 1'b0;
        end else begin
            // A fresh session forgets the error of the previous one.
            if (sess_rise) begin
                tout_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (in_range) begin
                            ram_addr_q <= bus.hps_addr[AW-1:0];
                            timer_q    <= 8'd0;
                            state_q    <= ST_ARM;
                        end else begin
                            // Bytes past the NVRAM end read as erased memory.
                            hps_din_q  <= 8'hFF;
                        end
                    end
                end
                ST_ARM: begin
                    state_q <= sess ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (!sess) begin
                        // Session abandoned: drop the fetch, keep the last byte.
                        state_q    <= ST_IDLE;
                    end else if (bus.ram_ok) begin
                        // Data wins over a timeout in the same cycle.
                        hps_din_q  <= bus.ram_dout;
                        state_q    <= ST_IDLE;
                    end else if (timeout) begin
                        hps_din_q  <= 8'hFF;
                        tout_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        timer_q    <= timer_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Follow the session one cycle late and pulse once when it ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uploading_q  <= 1'b0;
            upload_end_q <= 1'b0;
        end else begin
            uploading_q  <= uploading_d;
            upload_end_q <= uploading_q && !uploading_d;
        end
    end

    // hps_wait must rise on the request cycle itself so hps_io stalls at once;
    // out-of-range bytes are answered on the next edge and never stall.
    assign bus.hps_wait   = (state_q != ST_IDLE) || (req && in_range);
    assign bus.ram_cs     = (state_q == ST_ARM) || (state_q == ST_WAIT);
    assign bus.ram_addr   = ram_addr_q;
    assign bus.hps_din    = hps_din_q;
    assign bus.tout_err   = tout_err_q;
    assign bus.uploading  = uploading_q;
    assign bus.upload_end = upload_end_q;

endmodule

// File: tb/tb_jtframe_nvram_upload.sv
// Purpose: self-checking bench for jtframe_nvram_upload (scoreboard of expected responses).
// Latency: responses are checked for byte, error flag, hps_wait and cycle count from request.
// Backpressure: the bench only issues a new request once ram_cs has dropped.
module tb_jtframe_nvram_upload;

    localparam int AW = 13;

    typedef struct {
        string      name;
        logic [7:0] din;
        logic       terr;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtframe_nvram_upload_if #(.AW(AW)) bus();

    jtframe_nvram_upload #(
        .AW          (AW),
        .NVRAM_INDEX (8'd2),
        .TOUT        (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [7:0] mem [0:8191];
    bit         auto_ram = 1'b0;
    int         ok_dly   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [7:0] din, input logic terr, input int lat);
        exp_t e;
        e.name = name;
        e.din  = din;
        e.terr = terr;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the current fetch to finish (ram_cs low).
    task automatic wait_idle(input string name, input int limit);
        for (int n = 0; n < limit && bus.ram_cs; n++) step();
        check({name, "_done"}, bus.ram_cs, 1'b0);
    endtask

    // Model NVRAM: ram_ok rises ok_dly cycles after ram_cs, data from mem.
    initial begin
        int cs_cnt;
        cs_cnt = 0;
        forever begin
            step();
            if (auto_ram) begin
                if (bus.ram_cs) cs_cnt++;
                else            cs_cnt = 0;
                bus.ram_ok   = bus.ram_cs && (cs_cnt > ok_dly);
                bus.ram_dout = mem[bus.ram_addr];
            end
        end
    end

    // Monitor: a response is the first cycle after an accepted request with ram_cs low.
    initial begin
        exp_t e;
        bit   pend;
        int   t0, cyc;
        logic sess_tb, exp_wait;
        pend = 1'b0;
        t0   = 0;
        cyc  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                sess_tb = bus.hps_upload && (bus.hps_index == 8'd2);
                if (pend && cyc > t0 && !bus.ram_cs) begin
                    pend = 1'b0;
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_response: got din 0x%0h, expected no response", bus.hps_din);
                    end else begin
                        e = sb.pop_front();
                        exp_wait = bus.hps_rd && sess_tb && (bus.hps_addr < 27'd8192);
                        check({e.name, "_din"},  bus.hps_din,  e.din);
                        check({e.name, "_terr"}, bus.tout_err, e.terr);
                        check({e.name, "_wait"}, bus.hps_wait, exp_wait);
                        if (e.lat >= 0) check({e.name, "_lat"}, cyc - t0, e.lat);
                    end
                end
                if (!pend && bus.hps_rd && sess_tb) begin
                    pend = 1'b1;
                    t0   = cyc;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        bus.hps_upload = 1'b0;
        bus.hps_index  = 8'd0;
        bus.hps_rd     = 1'b0;
        bus.hps_addr   = 27'd0;
        bus.ram_ok     = 1'b0;
        bus.ram_dout   = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_din",        bus.hps_din,    8'h00);
        check("rst_ram_addr",   bus.ram_addr,   13'h0);
        check("rst_ram_cs",     bus.ram_cs,     1'b0);
        check("rst_wait",       bus.hps_wait,   1'b0);
        check("rst_uploading",  bus.uploading,  1'b0);
        check("rst_upload_end", bus.upload_end, 1'b0);
        check("rst_tout_err",   bus.tout_err,   1'b0);
        rst_n = 1'b1;
        step();

        // Open an NVRAM session
        bus.hps_upload = 1'b1;
        bus.hps_index  = 8'd2;
        step();
        @(negedge clk);
        check("sess_uploading", bus.uploading, 1'b1);
        step();

        // Normal byte: addr 0x10, ram_ok at cycle 4, done at cycle 5
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h10;          // cycle 0
        push("normal", 8'h5A, 1'b0, 5);
        @(negedge clk);
        check("normal_wait_c0", bus.hps_wait, 1'b1);
        check("normal_cs_c0",   bus.ram_cs,   1'b0);
        step(); bus.hps_rd = 1'b0;                          // cycle 1
        @(negedge clk);
        check("normal_cs_c1",   bus.ram_cs,   1'b1);
        check("normal_addr_c1", bus.ram_addr, 13'h0010);
        step();                                             // cycle 2
        step();                                             // cycle 3
        step();                                             // cycle 4
        bus.ram_ok = 1'b1; bus.ram_dout = 8'h5A;
        @(negedge clk);
        check("normal_cs_c4",   bus.ram_cs,   1'b1);
        step();                                             // cycle 5
        bus.ram_ok = 1'b0; bus.ram_dout = 8'h00;
        step();

        // Stale ram_ok held through ARM: captured only from WAIT (cycle 2)
        bus.ram_ok = 1'b1; bus.ram_dout = 8'h33;
        step();
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h123;          // cycle 0
        push("stale", 8'hC3, 1'b0, 3);
        step(); bus.hps_rd = 1'b0;                          // cycle 1 (ARM, ok ignored)
        step(); bus.ram_dout = 8'hC3;                       // cycle 2 (WAIT)
        step(); bus.ram_ok = 1'b0; bus.ram_dout = 8'h00;    // cycle 3
        step();

        // Timeout: no ram_ok, result at cycle 258
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h5;
        push("timeout", 8'hFF, 1'b1, 258);
        step(); bus.hps_rd = 1'b0;
        wait_idle("timeout", 300);
        step();

        // Highest in-range address; tout_err stays sticky
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h1FFF;
        push("top_addr", 8'h81, 1'b1, 3);
        step(); bus.hps_rd = 1'b0;                          // cycle 1
        @(negedge clk);
        check("top_addr_ram_addr", bus.ram_addr, 13'h1FFF);
        step(); bus.ram_ok = 1'b1; bus.ram_dout = 8'h81;    // cycle 2
        step(); bus.ram_ok = 1'b0; bus.ram_dout = 8'h00;    // cycle 3
        step();

        // Out of range: first address past the window, then a high alias
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h2000;
        push("oob", 8'hFF, 1'b1, 1);
        step(); bus.hps_rd = 1'b0;
        @(negedge clk);
        check("oob_cs", bus.ram_cs, 1'b0);
        step();
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h4000010;
        push("oob_high", 8'hFF, 1'b1, 1);
        step(); bus.hps_rd = 1'b0;
        @(negedge clk);
        check("oob_high_cs",       bus.ram_cs,   1'b0);
        check("oob_high_ram_addr", bus.ram_addr, 13'h1FFF);
        step();

        // Close and reopen the session: upload_end pulse, tout_err cleared
        bus.hps_upload = 1'b0;
        step();
        @(negedge clk);
        check("end1_uploading",  bus.uploading,  1'b0);
        check("end1_upload_end", bus.upload_end, 1'b1);
        check("end1_tout_err",   bus.tout_err,   1'b1);
        step();
        @(negedge clk);
        check("end1_pulse_off",  bus.upload_end, 1'b0);
        step();
        bus.hps_upload = 1'b1;
        step();
        @(negedge clk);
        check("sess2_uploading", bus.uploading, 1'b1);
        check("sess2_tout_clr",  bus.tout_err,  1'b0);
        step();

        // Normal read in the new session, ram_ok on the first WAIT cycle
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h20;
        push("sess2", 8'h96, 1'b0, 3);
        step(); bus.hps_rd = 1'b0;
        step(); bus.ram_ok = 1'b1; bus.ram_dout = 8'h96;
        step(); bus.ram_ok = 1'b0; bus.ram_dout = 8'h00;
        step();

        // Abort: session drops in WAIT, hps_din keeps the previous byte
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h42;           // cycle 0
        push("abort", 8'h96, 1'b0, 4);
        step(); bus.hps_rd = 1'b0;                          // cycle 1
        step();                                             // cycle 2
        step(); bus.hps_upload = 1'b0;                      // cycle 3
        @(negedge clk);
        check("abort_c3_cs",         bus.ram_cs,     1'b1);
        check("abort_c3_upload_end", bus.upload_end, 1'b0);
        step();                                             // cycle 4
        @(negedge clk);
        check("abort_c4_cs",         bus.ram_cs,     1'b0);
        check("abort_c4_wait",       bus.hps_wait,   1'b0);
        check("abort_c4_uploading",  bus.uploading,  1'b0);
        check("abort_c4_upload_end", bus.upload_end, 1'b1);
        step();                                             // cycle 5
        @(negedge clk);
        check("abort_c5_upload_end", bus.upload_end, 1'b0);
        step();

        // Wrong index: request must be ignored
        bus.hps_upload = 1'b1; bus.hps_index = 8'd0;
        step();
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h10;
        @(negedge clk);
        check("wrongidx_wait_c0", bus.hps_wait, 1'b0);
        step(); bus.hps_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrongidx_cs",        bus.ram_cs,    1'b0);
            check("wrongidx_din",       bus.hps_din,   8'h96);
            check("wrongidx_uploading", bus.uploading, 1'b0);
            step();
        end

        // Asynchronous reset in the middle of a fetch
        bus.hps_index = 8'd2;
        step(); step();
        bus.hps_rd = 1'b1; bus.hps_addr = 27'h77;           // cycle 0
        step(); bus.hps_rd = 1'b0;                          // cycle 1
        step();                                             // cycle 2
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs",        bus.ram_cs,    1'b0);
        check("arst_wait",      bus.hps_wait,  1'b0);
        check("arst_din",       bus.hps_din,   8'h00);
        check("arst_ram_addr",  bus.ram_addr,  13'h0);
        check("arst_uploading", bus.uploading, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();

        // Full sweep, back-to-back, random 0..10 cycle ram_ok latency
        auto_ram = 1'b1;
        for (int a = 0; a < 8192; a++) begin
            d = $urandom_range(10, 0);
            ok_dly = d;
            bus.hps_rd = 1'b1; bus.hps_addr = 27'(a);
            push("sweep", mem[a], 1'b0, (d < 1) ? 3 : 2 + d);
            step(); bus.hps_rd = 1'b0;
            wait_idle("sweep", 20);
        end
        auto_ram = 1'b0;
        bus.ram_ok = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("sweep_tout_err", bus.tout_err, 1'b0);
        check("sb_empty",       sb.size(),    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
